// File: rtl/sort_seq.sv
// Batch sequencer: loads N words, bubble-sorts them ascending through one shared
// comparator, then streams them out. Define SORT_SEQ_EARLY_EXIT_EN to stop after a swap-free pass.

module sort_seq_cmp #(
    parameter int W = 4
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         lt,
    output logic         gt,
    output logic         eq
);

    always_comb begin
        lt = (a < b);
        gt = (a > b);
        eq = (a == b);
    end

endmodule

module sort_seq #(
    parameter int N = 8,
    parameter int W = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    input  logic [W-1:0]         in_data,
    output logic                 in_ready,
    output logic                 out_valid,
    output logic [W-1:0]         out_data,
    input  logic                 out_ready,
    output logic                 busy,
    output logic                 done,
    output logic [$clog2(N)-1:0] pass_cnt
);

    localparam int IW = $clog2(N);
    localparam logic [IW-1:0] LAST_IDX  = IW'(N - 1);
    localparam logic [IW-1:0] LAST_PASS = IW'(N - 2);

    typedef enum logic [1:0] {
        LOAD,
        SORT,
        DRAIN
    } state_t;

    state_t        state_q, state_d;
    logic [W-1:0]  mem_q [N];
    logic [W-1:0]  mem_d [N];
    logic [IW-1:0] wr_idx_q, wr_idx_d;
    logic [IW-1:0] rd_idx_q, rd_idx_d;
    logic [IW-1:0] j_q, j_d;
    logic [IW-1:0] p_q, p_d;
    logic [IW-1:0] pass_cnt_q, pass_cnt_d;
    logic          in_ready_q, in_ready_d;
    logic          out_valid_q, out_valid_d;
    logic [W-1:0]  out_data_q, out_data_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
`ifdef SORT_SEQ_EARLY_EXIT_EN
    logic          swap_q, swap_d;
`endif

    logic          cmp_lt, cmp_gt, cmp_eq;
    logic          do_swap;
    logic          pass_end;
    logic          sort_end;
    logic [IW-1:0] last_j;
    logic [IW-1:0] j_next_idx;

    assign j_next_idx = j_q + IW'(1);

    sort_seq_cmp #(.W(W)) u_cmp (
        .a  (mem_q[j_q]),
        .b  (mem_q[j_next_idx]),
        .lt (cmp_lt),
        .gt (cmp_gt),
        .eq (cmp_eq)
    );

    always_comb begin
        state_d     = state_q;
        mem_d       = mem_q;
        wr_idx_d    = wr_idx_q;
        rd_idx_d    = rd_idx_q;
        j_d         = j_q;
        p_d         = p_q;
        pass_cnt_d  = pass_cnt_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
`ifdef SORT_SEQ_EARLY_EXIT_EN
        swap_d      = swap_q;
`endif
        // Equal keys never swap, which keeps the sort stable.
        do_swap     = cmp_gt && !(cmp_lt || cmp_eq);
        last_j      = LAST_PASS - p_q;
        pass_end    = 1'b0;
        sort_end    = 1'b0;

        case (state_q)
            LOAD: begin
                if (in_valid && in_ready_q) begin
                    mem_d[wr_idx_q] = in_data;
                    wr_idx_d        = wr_idx_q + IW'(1);
                    if (wr_idx_q == '0) begin
                        pass_cnt_d = '0;
                    end
                    if (wr_idx_q == LAST_IDX) begin
                        state_d    = SORT;
                        wr_idx_d   = '0;
                        j_d        = '0;
                        p_d        = '0;
                        in_ready_d = 1'b0;
                        busy_d     = 1'b1;
`ifdef SORT_SEQ_EARLY_EXIT_EN
                        swap_d     = 1'b0;
`endif
                    end
                end
            end

            SORT: begin
                if (do_swap) begin
                    mem_d[j_q]        = mem_q[j_next_idx];
                    mem_d[j_next_idx] = mem_q[j_q];
                end
`ifdef SORT_SEQ_EARLY_EXIT_EN
                swap_d = swap_q || do_swap;
`endif
                pass_end = (j_q == last_j);
                if (pass_end) begin
                    p_d        = p_q + IW'(1);
                    pass_cnt_d = p_q + IW'(1);
                    j_d        = '0;
`ifdef SORT_SEQ_EARLY_EXIT_EN
                    swap_d     = 1'b0;
                    sort_end   = (p_q == LAST_PASS) || !(swap_q || do_swap);
`else
                    sort_end   = (p_q == LAST_PASS);
`endif
                end else begin
                    j_d = j_next_idx;
                end
                // The first output word reflects this cycle's swap as well.
                if (sort_end) begin
                    state_d     = DRAIN;
                    busy_d      = 1'b0;
                    done_d      = 1'b1;
                    out_valid_d = 1'b1;
                    out_data_d  = mem_d[0];
                    rd_idx_d    = '0;
                end
            end

            DRAIN: begin
                if (out_valid_q && out_ready) begin
                    if (rd_idx_q == LAST_IDX) begin
                        state_d     = LOAD;
                        out_valid_d = 1'b0;
                        in_ready_d  = 1'b1;
                        rd_idx_d    = '0;
                        wr_idx_d    = '0;
                    end else begin
                        rd_idx_d   = rd_idx_q + IW'(1);
                        out_data_d = mem_q[rd_idx_q + IW'(1)];
                    end
                end
            end

            default: begin
                state_d = LOAD;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= LOAD;
            wr_idx_q    <= '0;
            rd_idx_q    <= '0;
            j_q         <= '0;
            p_q         <= '0;
            pass_cnt_q  <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
`ifdef SORT_SEQ_EARLY_EXIT_EN
            swap_q      <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            wr_idx_q    <= wr_idx_d;
            rd_idx_q    <= rd_idx_d;
            j_q         <= j_d;
            p_q         <= p_d;
            pass_cnt_q  <= pass_cnt_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
`ifdef SORT_SEQ_EARLY_EXIT_EN
            swap_q      <= swap_d;
`endif
        end
        mem_q <= mem_d;
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass_cnt  = pass_cnt_q;

endmodule
